// File: rtl/icache_assoc.sv
// icache_assoc: parametrised set-associative instruction cache.
// Same-cycle hit path, valid/ready line request, multi-beat ascending refill,
// per-set round-robin replacement and a one-set-per-cycle full flush.
// Optional hit/miss statistics counters are built when ICACHE_STATS_EN is defined.
module icache_assoc #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned LINE_WORDS = 8,
    parameter int unsigned SETS       = 1024,
    parameter int unsigned WAYS       = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              fetch_valid,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [31:0]       fetch_data,
    output logic              stop,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_resp_valid,
    input  logic [31:0]       mem_resp_data,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
);

    localparam int unsigned OFS_W = $clog2(LINE_WORDS);
    localparam int unsigned IDX_W = $clog2(SETS);
    localparam int unsigned TAG_W = ADDR_W - OFS_W - IDX_W - 2;
    localparam int unsigned WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [1:0] {IDLE, REQ, FILL, FLUSH} state_t;

    state_t state, state_nxt;

    logic [TAG_W-1:0] f_tag;
    logic [IDX_W-1:0] f_idx;
    logic [OFS_W-1:0] f_ofs;
    logic             unused_addr_lsb;

    assign f_ofs           = fetch_addr[OFS_W+1:2];
    assign f_idx           = fetch_addr[OFS_W+IDX_W+1:OFS_W+2];
    assign f_tag           = fetch_addr[ADDR_W-1:OFS_W+IDX_W+2];
    assign unused_addr_lsb = ^fetch_addr[1:0];

    // storage: valid bits are flops, tags/data are plain arrays
    logic [SETS-1:0]  valid_q  [WAYS];
    logic [TAG_W-1:0] tag_mem  [WAYS][SETS];
    logic [31:0]      data_mem [WAYS][SETS][LINE_WORDS];
    logic [WAY_W-1:0] rr_ptr;

    // miss bookkeeping
    logic [TAG_W-1:0] req_tag;
    logic [IDX_W-1:0] req_idx;
    logic [WAY_W-1:0] victim_q;
    logic [OFS_W-1:0] beat;
    logic             flush_pending;
    logic [IDX_W-1:0] flush_idx;

    logic             hit;
    logic [WAY_W-1:0] hit_way;
    logic [WAY_W-1:0] victim_sel;
    logic             last_beat;
    logic             fill_done;

    assign last_beat = (beat == OFS_W'(LINE_WORDS - 1));
    assign fill_done = (state == FILL) && mem_resp_valid && last_beat;

    // tag compare across ways; lowest-numbered matching way wins
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        if (fetch_valid && state == IDLE) begin
            for (int unsigned w = 0; w < WAYS; w++) begin
                if (!hit && valid_q[w][f_idx] && tag_mem[w][f_idx] == f_tag) begin
                    hit     = 1'b1;
                    hit_way = WAY_W'(w);
                end
            end
        end
    end

    // hit word, zero otherwise
    always_comb begin
        fetch_data = '0;
        if (hit) fetch_data = data_mem[hit_way][f_idx][f_ofs];
    end

    // victim: lowest invalid way, else the set's round-robin pointer
    always_comb begin
        logic found;
        found      = 1'b0;
        victim_sel = rr_ptr;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (!found && !valid_q[w][f_idx]) begin
                found      = 1'b1;
                victim_sel = WAY_W'(w);
            end
        end
    end

    // next-state and handshake outputs
    always_comb begin
        state_nxt     = state;
        stop          = (state != IDLE) || (fetch_valid && !hit);
        mem_req_valid = (state == REQ);
        case (state)
            IDLE: begin
                if (flush)                              state_nxt = FLUSH;
                else if (fetch_valid && !hit && !stall) state_nxt = REQ;
            end
            REQ: begin
                if (mem_req_ready) state_nxt = FILL;
            end
            FILL: begin
                if (fill_done) state_nxt = (flush_pending || flush) ? FLUSH : IDLE;
            end
            FLUSH: begin
                if (flush_idx == IDX_W'(SETS - 1)) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // miss capture, beat counter, deferred flush and flush sweep index
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_tag       <= '0;
            req_idx       <= '0;
            victim_q      <= '0;
            beat          <= '0;
            flush_pending <= 1'b0;
            flush_idx     <= '0;
            mem_req_addr  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (state_nxt == REQ) begin
                        req_tag      <= f_tag;
                        req_idx      <= f_idx;
                        victim_q     <= victim_sel;
                        mem_req_addr <= {f_tag, f_idx, {(OFS_W+2){1'b0}}};
                    end
                end
                REQ: begin
                    if (flush)         flush_pending <= 1'b1;
                    if (mem_req_ready) beat <= '0;
                end
                FILL: begin
                    if (mem_resp_valid) beat <= beat + 1'b1;
                    if (fill_done)      flush_pending <= 1'b0;
                    else if (flush)     flush_pending <= 1'b1;
                end
                FLUSH: begin
                    // wraps back to 0 on the last set, ready for the next flush
                    flush_idx <= flush_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // valid bits: set on fill completion, cleared set-by-set during flush
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned w = 0; w < WAYS; w++) valid_q[w] <= '0;
        end else if (fill_done) begin
            valid_q[victim_q][req_idx] <= 1'b1;
        end else if (state == FLUSH) begin
            for (int unsigned w = 0; w < WAYS; w++) valid_q[w][flush_idx] <= 1'b0;
        end
    end

    // refill beats into the victim line; tag written with the last beat
    always_ff @(posedge clk) begin
        if (state == FILL && mem_resp_valid) begin
            data_mem[victim_q][req_idx][beat] <= mem_resp_data;
            if (last_beat) tag_mem[victim_q][req_idx] <= req_tag;
        end
    end

    generate
        if (WAYS > 1) begin : g_rr
            logic [WAY_W-1:0] rr_q [SETS];

            // per-set round-robin pointer; WAYS is a power of 2 so the add wraps
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    for (int unsigned s = 0; s < SETS; s++) rr_q[s] <= '0;
                end else if (fill_done) begin
                    rr_q[req_idx] <= victim_q + 1'b1;
                end else if (state == FLUSH) begin
                    rr_q[flush_idx] <= '0;
                end
            end

            assign rr_ptr = rr_q[f_idx];
        end else begin : g_no_rr
            assign rr_ptr = '0;
        end
    endgenerate

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_q;
    logic [31:0] miss_q;

    // saturating statistics, cleared only by reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hit_q  <= '0;
            miss_q <= '0;
        end else begin
            if (hit && !stall && hit_q != '1)                  hit_q  <= hit_q + 32'd1;
            if (state == IDLE && state_nxt == REQ && miss_q != '1) miss_q <= miss_q + 32'd1;
        end
    end

    assign hit_count  = hit_q;
    assign miss_count = miss_q;
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule

// File: tb/tb_icache_assoc.sv
// tb_icache_assoc: directed scoreboard bench for icache_assoc (default parameters).
module tb_icache_assoc;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        fetch_valid = 1'b0;
    logic [31:0] fetch_addr = '0;
    logic [31:0] fetch_data;
    logic        stop;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [31:0] mem_req_addr;
    logic        mem_resp_valid = 1'b0;
    logic [31:0] mem_resp_data = '0;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    icache_assoc #(.ADDR_W(32), .LINE_WORDS(8), .SETS(1024), .WAYS(2)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .fetch_valid(fetch_valid), .fetch_addr(fetch_addr), .fetch_data(fetch_data),
        .stop(stop), .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_resp_valid(mem_resp_valid),
        .mem_resp_data(mem_resp_data), .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned id;
        logic        stop;
        logic [31:0] data;
        logic        reqv;
    } fexp_t;

    fexp_t       exp_q[$];
    logic [31:0] req_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    int unsigned vid = 0;
    int          exp_hits = 0;
    int          exp_misses = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec = n_vec + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    task automatic push_f(logic s, logic [31:0] d, logic rv);
        fexp_t e;
        e.id   = vid;
        e.stop = s;
        e.data = d;
        e.reqv = rv;
        vid    = vid + 1;
        exp_q.push_back(e);
        if (!s) exp_hits = exp_hits + 1;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // every fetch_valid cycle is one response to score
    always @(negedge clk) begin
        if (reset && fetch_valid) begin
            if (exp_q.size() == 0) begin
                chk("fetch_unexpected", 32'd1, 32'd0);
            end else begin
                fexp_t e;
                e = exp_q.pop_front();
                chk($sformatf("stop#%0d", e.id), {31'b0, stop}, {31'b0, e.stop});
                chk($sformatf("data#%0d", e.id), fetch_data, e.data);
                chk($sformatf("reqv#%0d", e.id), {31'b0, mem_req_valid}, {31'b0, e.reqv});
            end
        end
        if (reset && mem_req_valid) begin
            if (req_q.size() == 0) begin
                chk("req_spurious", mem_req_addr, 32'hFFFF_FFFF);
            end else begin
                chk("req_addr", mem_req_addr, req_q[0]);
                if (mem_req_ready) void'(req_q.pop_front());
            end
        end
    end

    task automatic fetch(logic [31:0] a, logic [31:0] d);
        fetch_valid = 1'b1;
        fetch_addr  = a;
        push_f(1'b0, d, 1'b0);
        cyc();
        fetch_valid = 1'b0;
    endtask

    // full miss with fetch held; optional stall, not-ready and flush-at-beat
    task automatic miss_fill(logic [31:0] a, logic [31:0] base, logic [31:0] raddr,
                             int stall_n, int nrdy_n, int flush_beat, logic [31:0] hit_d);
        int n;
        fetch_valid = 1'b1;
        fetch_addr  = a;
        req_q.push_back(raddr);
        exp_misses = exp_misses + 1;
        if (stall_n > 0) begin
            stall = 1'b1;
            repeat (stall_n) begin push_f(1'b1, 32'd0, 1'b0); cyc(); end
            stall = 1'b0;
        end
        push_f(1'b1, 32'd0, 1'b0); cyc();
        repeat (nrdy_n) begin push_f(1'b1, 32'd0, 1'b1); cyc(); end
        mem_req_ready = 1'b1;
        push_f(1'b1, 32'd0, 1'b1); cyc();
        mem_req_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = base + i;
            flush = (i == flush_beat);
            push_f(1'b1, 32'd0, 1'b0); cyc();
            flush = 1'b0;
        end
        mem_resp_valid = 1'b0;
        if (flush_beat >= 0) begin
            fetch_valid = 1'b0;
            n = 0;
            while (stop && n < 2000) begin cyc(); n = n + 1; end
            chk("flush_cycles", n, 32'd1024);
        end else begin
            push_f(1'b0, hit_d, 1'b0); cyc();
            fetch_valid = 1'b0;
        end
    endtask

    task automatic check_stats(string tag);
`ifdef ICACHE_STATS_EN
        chk({tag, "_hits"}, hit_count, exp_hits);
        chk({tag, "_misses"}, miss_count, exp_misses);
`else
        chk({tag, "_hits"}, hit_count, 32'd0);
        chk({tag, "_misses"}, miss_count, 32'd0);
`endif
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        #12;
        chk("rst_stop", {31'b0, stop}, 32'd0);
        chk("rst_req_valid", {31'b0, mem_req_valid}, 32'd0);
        chk("rst_req_addr", mem_req_addr, 32'd0);
        chk("rst_hits", hit_count, 32'd0);
        chk("rst_misses", miss_count, 32'd0);
        cyc();
        reset = 1'b1;
        cyc();

        // first miss and hits in the same line
        miss_fill(32'h0000_1004, 32'hA0, 32'h0000_1000, 0, 0, -1, 32'hA1);
        fetch(32'h0000_101C, 32'hA7);

        // second way, then round-robin eviction of way 0
        miss_fill(32'h0000_9000, 32'hB0, 32'h0000_9000, 0, 0, -1, 32'hB0);
        fetch(32'h0000_1000, 32'hA0);
        fetch(32'h0000_9004, 32'hB1);
        miss_fill(32'h0001_1008, 32'hC0, 32'h0001_1000, 0, 0, -1, 32'hC2);
        fetch(32'h0000_9004, 32'hB1);
        miss_fill(32'h0000_1000, 32'hD0, 32'h0000_1000, 0, 0, -1, 32'hD0);

        // stall blocks the miss; memory back-pressure holds the request
        miss_fill(32'h0000_2004, 32'h20, 32'h0000_2000, 4, 0, -1, 32'h21);
        miss_fill(32'h0000_2810, 32'h28, 32'h0000_2800, 0, 5, -1, 32'h2C);

        // flush during a fill, then a previously cached line misses
        miss_fill(32'h0000_9000, 32'hE0, 32'h0000_9000, 0, 0, -1, 32'hE0);
        miss_fill(32'h0000_3000, 32'h30, 32'h0000_3000, 0, 0, 3, 32'h0);
        miss_fill(32'h0000_9008, 32'hF0, 32'h0000_9000, 0, 0, -1, 32'hF2);
        check_stats("stats");

        // reset in the middle of a fill
        fetch_valid = 1'b1;
        fetch_addr  = 32'h0000_1004;
        req_q.push_back(32'h0000_1000);
        push_f(1'b1, 32'd0, 1'b0); cyc();
        mem_req_ready = 1'b1;
        push_f(1'b1, 32'd0, 1'b1); cyc();
        mem_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = 32'h50 + i;
            push_f(1'b1, 32'd0, 1'b0); cyc();
        end
        fetch_valid    = 1'b0;
        mem_resp_valid = 1'b0;
        reset          = 1'b0;
        #1;
        chk("midrst_stop", {31'b0, stop}, 32'd0);
        chk("midrst_req_valid", {31'b0, mem_req_valid}, 32'd0);
        chk("midrst_req_addr", mem_req_addr, 32'd0);
        chk("midrst_misses", miss_count, 32'd0);
        exp_hits   = 0;
        exp_misses = 0;
        cyc();
        cyc();
        reset = 1'b1;
        cyc();
        miss_fill(32'h0000_1004, 32'hA0, 32'h0000_1000, 0, 0, -1, 32'hA1);
        check_stats("post_rst");

        cyc();
        cyc();
        chk("fetch_queue_drained", exp_q.size(), 32'd0);
        chk("req_queue_drained", req_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/icache_assoc.md
Name: icache_assoc

Overview:
Parametrised set-associative instruction cache sitting between the fetch stage and the instruction memory port. It is the successor to the direct-mapped IC and generalises line size, set count and associativity. It adds a valid/ready memory request handshake, a multi-beat line refill, round-robin replacement and a full-cache flush. Hits return data combinationally in the same cycle. Misses hold the fetch stage with `stop` until the line is filled.

Parameters:
- ADDR_W, 32, address width in bits.
- LINE_WORDS, 8, 32-bit words per line; power of 2, ≥2.
- SETS, 1024, number of sets; power of 2.
- WAYS, 2, associativity; allowed values 1, 2, 4.

Ports:
- clk  in  1  clock.
- reset  in  1  async active-low reset.
- stall  in  1  pipeline freeze; blocks miss start and hit counting.
- flush  in  1  one-cycle pulse; invalidate all lines.
- fetch_valid  in  1  fetch_addr is meaningful.
- fetch_addr  in  ADDR_W  byte address; bits [1:0] ignored.
- fetch_data  out  32  hit word; 0 when no hit.
- stop  out  1  fetch must hold; data not valid.
- mem_req_valid  out  1  line request pending.
- mem_req_ready  in  1  memory accepts request.
- mem_req_addr  out  ADDR_W  line-aligned request address.
- mem_resp_valid  in  1  one refill beat present.
- mem_resp_data  in  32  refill word, ascending word order.
- hit_count  out  32  stats (see Optional Feature).
- miss_count  out  32  stats (see Optional Feature).

Behaviour:
- Address split:
  - OFS_W = log2(LINE_WORDS), IDX_W = log2(SETS).
  - Word offset = addr[OFS_W+1:2]; index = addr[OFS_W+IDX_W+1:OFS_W+2]; tag = remaining upper bits.
- Per-way storage: valid bit (flop), tag, LINE_WORDS data words.
- Per-set storage: round-robin pointer, log2(WAYS) bits, reset 0.
- Hit = fetch_valid & state==IDLE & some way valid with matching tag.
- stop = (state!=IDLE) | (fetch_valid & ~hit). Purely combinational.
- fetch_data = selected word of the hit way, else 0.
- FSM states: IDLE, REQ, FILL, FLUSH.
- IDLE:
  - If flush → FLUSH. Flush has priority over a simultaneous miss.
  - Else if fetch_valid & ~hit & ~stall → REQ. Latch tag and index; choose victim.
  - Victim choice: lowest-numbered invalid way; if none, the pointer's way.
- REQ:
  - mem_req_valid=1; mem_req_addr = {tag, index, zeros}.
  - Both held stable until mem_req_ready. Then → FILL with beat=0.
- FILL:
  - Each mem_resp_valid cycle writes mem_resp_data to word[beat] of the victim way, then beat++.
  - On beat LINE_WORDS-1: write the tag, set valid, set the set's pointer to (victim+1) mod WAYS, → IDLE.
  - The next cycle's lookup hits. There is no early hit on a partially filled line.
- stall is ignored in REQ and FILL; refill beats are always accepted.
- flush arriving in REQ or FILL sets flush_pending. After the fill completes, → FLUSH instead of IDLE.
- FLUSH:
  - Clears all valid bits of one set per cycle, SETS cycles in total, stop=1.
  - Round-robin pointers are cleared too. Then → IDLE.
  - flush arriving during FLUSH is ignored.
- WAYS=1: victim is always way 0; no pointer storage.
- Reset (async, mid-operation included):
  - state=IDLE; all valid bits, pointers, beat and flush_pending = 0.
  - mem_req_valid=0, mem_req_addr=0, counters=0.
  - The memory side is reset by the same reset, so no stale beats arrive after reset.

Optional Feature:
- Macro: ICACHE_STATS_EN.
- Defined:
  - hit_count increments on each cycle with hit & ~stall.
  - miss_count increments on each IDLE→REQ transition.
  - Both saturate at 0xFFFFFFFF and are cleared only by reset, not by flush.
- Undefined: both ports are driven constant 0 and no counter flops are built.

Test Plan (defaults, 2 ways):
- Reset, then fetch 0x0000_1004 → stop=1, mem_req_addr=0x0000_1000. Return 8 beats 0xA0..0xA7 → next cycle stop=0, fetch_data=0xA1. Fetch 0x0000_101C → 0xA7 with no request.
- Fill 0x0000_1000 (way0), then 0x0000_9000 (same index 0x080, way1) → both hit. Fill 0x0001_1000 → evicts way0; fetch 0x0000_1000 misses again, 0x0000_9000 still hits.
- Missing fetch with stall=1 for 4 cycles → stop=1, mem_req_valid=0 throughout. Release stall → mem_req_valid=1 the next cycle.
- mem_req_ready=0 for 5 cycles → mem_req_valid=1 and mem_req_addr unchanged throughout. One ready cycle → FILL.
- flush pulse at beat 3 of a fill → remaining beats accepted, then 1024 FLUSH cycles with stop=1. Previously cached 0x0000_9000 then misses. With ICACHE_STATS_EN, miss_count counts each miss exactly once.
- reset asserted mid-FILL at beat 3 → mem_req_valid=0 immediately. After release, fetch 0x0000_1004 misses and re-requests 0x0000_1000.
